// File: rtl/alu_result_stage_pkg.sv
// Shared ALU definitions: flag bit positions and branch condition codes.
// Used by the ALU, the sequencer and the result stage.
package alu_result_stage_pkg;

  localparam logic [1:0] FLAG_Z = 2'd0;
  localparam logic [1:0] FLAG_C = 2'd1;
  localparam logic [1:0] FLAG_N = 2'd2;
  localparam logic [1:0] FLAG_V = 2'd3;

  typedef enum logic [3:0] {
    COND_BRA = 4'd0,
    COND_BRN = 4'd1,
    COND_HI  = 4'd2,
    COND_LS  = 4'd3,
    COND_CC  = 4'd4,
    COND_CS  = 4'd5,
    COND_NE  = 4'd6,
    COND_EQ  = 4'd7,
    COND_VC  = 4'd8,
    COND_VS  = 4'd9,
    COND_PL  = 4'd10,
    COND_MI  = 4'd11,
    COND_GE  = 4'd12,
    COND_LT  = 4'd13,
    COND_GT  = 4'd14,
    COND_LE  = 4'd15
  } cond_e;

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, the result stage and its downstream consumer.
// master = environment side (ALU + consumer), slave = result stage.
interface alu_result_stage_if #(
  parameter int N        = 8,
  parameter int FlagBits = 4
);
  logic [N-1:0]        y;
  logic [FlagBits-1:0] oflags;
  logic [FlagBits-1:0] flag_mask;
  logic                load_res;
  logic                in_valid;
  logic                in_ready;
  logic [N-1:0]        result;
  logic                res_valid;
  logic                res_ready;

  modport master (
    output y, oflags, flag_mask, load_res, in_valid, res_ready,
    input  in_ready, result, res_valid
  );

  modport slave (
    input  y, oflags, flag_mask, load_res, in_valid, res_ready,
    output in_ready, result, res_valid
  );
endinterface

// File: rtl/alu_result_stage_cond_eval.sv
// Pure combinational branch condition evaluator over the {V,N,C,Z} flag vector.
module cond_eval
  import alu_result_stage_pkg::*;
#(
  parameter int FlagBits = 4
) (
  input  logic [3:0]          cond_i,
  input  logic [FlagBits-1:0] flags_i,
  output logic                cond_true_o
);

  logic z, c, n, v;
  cond_e cond;

  assign z    = flags_i[FLAG_Z];
  assign c    = flags_i[FLAG_C];
  assign n    = flags_i[FLAG_N];
  assign v    = flags_i[FLAG_V];
  assign cond = cond_e'(cond_i);

  always_comb begin
    cond_true_o = 1'b0;
    unique case (cond)
      COND_BRA: cond_true_o = 1'b1;
      COND_BRN: cond_true_o = 1'b0;
      COND_HI:  cond_true_o = !c && !z;
      COND_LS:  cond_true_o = c || z;
      COND_CC:  cond_true_o = !c;
      COND_CS:  cond_true_o = c;
      COND_NE:  cond_true_o = !z;
      COND_EQ:  cond_true_o = z;
      COND_VC:  cond_true_o = !v;
      COND_VS:  cond_true_o = v;
      COND_PL:  cond_true_o = !n;
      COND_MI:  cond_true_o = n;
      COND_GE:  cond_true_o = (n == v);
      COND_LT:  cond_true_o = (n != v);
      COND_GT:  cond_true_o = !z && (n == v);
      COND_LE:  cond_true_o = z || (n != v);
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result register with single-entry valid/ready handshake, masked flag register
// and branch condition output. Define ALU_FLAG_SAVE_EN to add the shadow flag register.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int N        = 8,
  parameter int FlagBits = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  alu_result_stage_if.slave   bus,
  input  logic [3:0]          cond_i,
  output logic                cond_true_o,
  output logic [FlagBits-1:0] iflags_o
`ifdef ALU_FLAG_SAVE_EN
  ,
  input  logic                flag_save_i,
  input  logic                flag_restore_i,
  output logic [FlagBits-1:0] saved_flags_o
`endif
);

  logic [N-1:0]        result_q, result_d;
  logic                res_valid_q, res_valid_d;
  logic [FlagBits-1:0] iflags_q, iflags_d;
  logic [FlagBits-1:0] flags_upd;
  logic                in_ready;
  logic                accept;

  // A draining entry frees the slot in the same cycle, so back-to-back beats see no bubble.
  assign in_ready = !res_valid_q || bus.res_ready;
  assign accept   = bus.in_valid && in_ready;

  assign flags_upd = accept ? ((iflags_q & ~bus.flag_mask) | (bus.oflags & bus.flag_mask))
                            : iflags_q;

  always_comb begin
    result_d    = result_q;
    res_valid_d = res_valid_q;
    if (accept && bus.load_res) begin
      result_d    = bus.y;
      res_valid_d = 1'b1;
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

`ifdef ALU_FLAG_SAVE_EN
  logic [FlagBits-1:0] shadow_q, shadow_d;

  // Save and restore together naturally swap: each side reads the other's old value.
  always_comb begin
    iflags_d = flags_upd;
    shadow_d = shadow_q;
    if (flag_save_i)    shadow_d = iflags_q;
    if (flag_restore_i) iflags_d = shadow_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign saved_flags_o = shadow_q;
`else
  assign iflags_d = flags_upd;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_q    <= '0;
      res_valid_q <= 1'b0;
      iflags_q    <= '0;
    end else begin
      result_q    <= result_d;
      res_valid_q <= res_valid_d;
      iflags_q    <= iflags_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.result    = result_q;
  assign bus.res_valid = res_valid_q;
  assign iflags_o      = iflags_q;

  cond_eval #(
    .FlagBits (FlagBits)
  ) u_cond_eval (
    .cond_i      (cond_i),
    .flags_i     (iflags_q),
    .cond_true_o (cond_true_o)
  );

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_alu_result_stage;
  import alu_result_stage_pkg::*;

  localparam int N  = 8;
  localparam int FB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    cond;
  logic          cond_true;
  logic [FB-1:0] iflags;
  logic          fsave, frest;
`ifdef ALU_FLAG_SAVE_EN
  logic [FB-1:0] saved;
`endif

  alu_result_stage_if #(.N(N), .FlagBits(FB)) bus();

  alu_result_stage #(.N(N), .FlagBits(FB)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus.slave),
    .cond_i      (cond),
    .cond_true_o (cond_true),
    .iflags_o    (iflags)
`ifdef ALU_FLAG_SAVE_EN
    ,
    .flag_save_i    (fsave),
    .flag_restore_i (frest),
    .saved_flags_o  (saved)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [N-1:0]  m_result;
  bit            m_valid;
  logic [FB-1:0] m_flags;
  logic [FB-1:0] m_shadow;
  logic [N-1:0]  seen[$];
  bit            exp_ready;
  bit            exp_cond;
  bit            shadow_bad;

  function automatic bit cond_ref(input logic [3:0] c, input logic [3:0] f);
    bit z, cy, n, v;
    z = f[0]; cy = f[1]; n = f[2]; v = f[3];
    case (cond_e'(c))
      COND_BRA: return 1'b1;
      COND_BRN: return 1'b0;
      COND_HI:  return !cy && !z;
      COND_LS:  return cy || z;
      COND_CC:  return !cy;
      COND_CS:  return cy;
      COND_NE:  return !z;
      COND_EQ:  return z;
      COND_VC:  return !v;
      COND_VS:  return v;
      COND_PL:  return !n;
      COND_MI:  return n;
      COND_GE:  return n == v;
      COND_LT:  return n != v;
      COND_GT:  return !z && (n == v);
      default:  return z || (n != v);
    endcase
  endfunction

  // Behavioural model: one transfer rule per edge, per-bit flag selection.
  always @(posedge clk) begin : model
    bit            ready, acc;
    logic [FB-1:0] nf;
    if (rst) begin
      m_result = '0; m_valid = 1'b0; m_flags = '0; m_shadow = '0;
    end else begin
      ready = !m_valid || bus.res_ready;
      acc   = bus.in_valid && ready;
      nf    = m_flags;
      if (acc)
        for (int b = 0; b < FB; b++)
          if (bus.flag_mask[b]) nf[b] = bus.oflags[b];
      if (acc && bus.load_res) begin
        m_result = bus.y;
        m_valid  = 1'b1;
      end else if (bus.res_ready) begin
        m_valid = 1'b0;
      end
`ifdef ALU_FLAG_SAVE_EN
      if (frest) nf = m_shadow;
      if (fsave) m_shadow = m_flags;
`endif
      m_flags = nf;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      exp_ready  = !m_valid || bus.res_ready;
      exp_cond   = cond_ref(cond, m_flags);
      shadow_bad = 1'b0;
`ifdef ALU_FLAG_SAVE_EN
      shadow_bad = (saved !== m_shadow);
`endif
      if (bus.in_ready !== exp_ready || bus.res_valid !== m_valid || bus.result !== m_result ||
          iflags !== m_flags || cond_true !== exp_cond || shadow_bad) begin
        n_fail++;
        $display("FAIL cycle_state t=%0t actual rdy=%b vld=%b res=%h flg=%b ct=%b required rdy=%b vld=%b res=%h flg=%b ct=%b shadow_bad=%b",
                 $time, bus.in_ready, bus.res_valid, bus.result, iflags, cond_true,
                 exp_ready, m_valid, m_result, m_flags, exp_cond, shadow_bad);
      end
      if (bus.res_valid === 1'b1 && bus.res_ready && !rst) seen.push_back(bus.result);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.load_res  = 1'b0;
    bus.flag_mask = '0;
    bus.oflags    = '0;
    bus.y         = '0;
    bus.res_ready = 1'b0;
    fsave         = 1'b0;
    frest         = 1'b0;
  endtask

  initial begin
    int  cnt;
    bit  acc;
    rst = 1'b1; cond = 4'd0; idle();
    step(); step();
    chk_en = 1'b1; rst = 1'b0;
    #1;
    chk("rst_result",   32'(bus.result),    32'h0);
    chk("rst_valid",    32'(bus.res_valid), 32'h0);
    chk("rst_iflags",   32'(iflags),        32'h0);
    chk("rst_in_ready", 32'(bus.in_ready),  32'h1);

    // first load: V and N set
    bus.y = 8'h80; bus.oflags = 4'b1100; bus.flag_mask = 4'hF;
    bus.load_res = 1'b1; bus.in_valid = 1'b1;
    step(); idle(); cond = 4'd13; #1;
    chk("load_result", 32'(bus.result),    32'h80);
    chk("load_valid",  32'(bus.res_valid), 32'h1);
    chk("load_iflags", 32'(iflags),        32'hC);
    chk("lt_false",    32'(cond_true),     32'h0);

    // flags-only accepts, drain alongside the first
    bus.in_valid = 1'b1; bus.oflags = 4'b0010; bus.flag_mask = 4'hF; bus.res_ready = 1'b1;
    step(); idle();
    chk("cmp_iflags_a", 32'(iflags), 32'h2);
    bus.in_valid = 1'b1; bus.oflags = 4'b0001; bus.flag_mask = 4'b0001;
    step(); idle(); cond = 4'd3; #1;
    chk("cmp_iflags_b", 32'(iflags),        32'h3);
    chk("cmp_valid",    32'(bus.res_valid), 32'h0);
    chk("ls_true",      32'(cond_true),     32'h1);

    // backpressure then same-edge drain and refill
    bus.y = 8'h11; bus.load_res = 1'b1; bus.in_valid = 1'b1;
    step(); idle();
    chk("bp_first", 32'(bus.result), 32'h11);
    bus.y = 8'h55; bus.load_res = 1'b1; bus.in_valid = 1'b1;
    bus.oflags = 4'hF; bus.flag_mask = 4'hF;
    repeat (3) begin
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
      step();
      chk("bp_result", 32'(bus.result), 32'h11);
      chk("bp_iflags", 32'(iflags),     32'h3);
    end
    bus.res_ready = 1'b1; #1;
    chk("bp_release_ready", 32'(bus.in_ready), 32'h1);
    step(); idle();
    chk("bp_refill_result", 32'(bus.result),    32'h55);
    chk("bp_refill_valid",  32'(bus.res_valid), 32'h1);
    chk("bp_refill_iflags", 32'(iflags),        32'hF);
    bus.res_ready = 1'b1; step(); idle();

    // reset overrides a pending accept
    bus.y = 8'h77; bus.load_res = 1'b1; bus.in_valid = 1'b1;
    step();
    bus.y = 8'h99; bus.oflags = 4'hF; bus.flag_mask = 4'hF; rst = 1'b1;
    step(); rst = 1'b0; idle(); #1;
    chk("rst2_valid",    32'(bus.res_valid), 32'h0);
    chk("rst2_iflags",   32'(iflags),        32'h0);
    chk("rst2_result",   32'(bus.result),    32'h0);
    chk("rst2_in_ready", 32'(bus.in_ready),  32'h1);

`ifdef ALU_FLAG_SAVE_EN
    bus.in_valid = 1'b1; bus.oflags = 4'b1010; bus.flag_mask = 4'hF;
    step(); idle();
    chk("save_pre", 32'(iflags), 32'hA);
    fsave = 1'b1; step(); idle();
    chk("save_shadow", 32'(saved), 32'hA);
    bus.in_valid = 1'b1; bus.oflags = 4'b0101; bus.flag_mask = 4'hF;
    step(); idle();
    chk("save_mid", 32'(iflags), 32'h5);
    frest = 1'b1; step(); idle();
    chk("restore", 32'(iflags), 32'hA);
`endif

    // ordered stream with random downstream readiness
    seen.delete();
    for (int v = 1; v <= 16; v++) begin
      bus.y = v[7:0]; bus.in_valid = 1'b1; bus.load_res = 1'b1;
      bus.oflags = 4'($urandom); bus.flag_mask = 4'($urandom);
      cnt = 0;
      do begin
        bus.res_ready = 1'($urandom_range(0, 1));
        acc = !m_valid || bus.res_ready;
        step();
        cnt++;
      end while (!acc && cnt < 50);
      if (!acc) chk("stream_timeout", 32'(cnt), 32'(0));
    end
    idle(); bus.res_ready = 1'b1;
    repeat (3) step();
    idle();
    chk("stream_count", 32'(seen.size()), 32'd16);
    for (int i = 0; i < seen.size() && i < 16; i++)
      chk("stream_order", 32'(seen[i]), 32'(i + 1));

    // random traffic
    repeat (400) begin
      rst           = ($urandom_range(0, 49) == 0);
      bus.in_valid  = 1'($urandom);
      bus.load_res  = 1'($urandom);
      bus.y         = 8'($urandom);
      bus.oflags    = 4'($urandom);
      bus.flag_mask = 4'($urandom);
      bus.res_ready = 1'($urandom);
      cond          = 4'($urandom);
      fsave         = ($urandom_range(0, 3) == 0);
      frest         = ($urandom_range(0, 3) == 0);
      step();
    end
    rst = 1'b0; idle(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter N, default 8: datapath width; matches the ALU width.
REQ-002 Parameter FlagBits, default 4: flag vector width, ordered V,N,C,Z (bit3..bit0).
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Y  input  N  ALU result (ALU OE held low while InValid=1).
REQ-006 OFlags  input  FlagBits  ALU output flags {V,N,C,Z}.
REQ-007 FlagMask  input  FlagBits  per-flag update enable; 1 = flag takes OFlags bit.
REQ-008 LoadRes  input  1  1 = result is forwarded; 0 = flags-only operation (compare/test).
REQ-009 InValid  input  1  upstream presents a valid ALU result.
REQ-010 InReady  output  1  stage can accept this cycle.
REQ-011 Result  output  N  registered result.
REQ-012 ResValid  output  1  Result holds an unconsumed value.
REQ-013 ResReady  input  1  downstream consumes Result this cycle.
REQ-014 IFlags  output  FlagBits  registered flags, fed back to ALU IFlags.
REQ-015 Cond  input  4  branch condition select.
REQ-016 CondTrue  output  1  combinational evaluation of Cond against IFlags.

Function
REQ-017 Accept = InValid & InReady; InReady = !ResValid | ResReady (single-entry register, no bubble on back-to-back).
REQ-018 On accept, flags SHALL update next edge: IFlags <= (IFlags & ~FlagMask) | (OFlags & FlagMask), regardless of LoadRes.
REQ-019 On accept with LoadRes=1: Result <= Y, ResValid <= 1; latency one cycle from accept to ResValid.
REQ-020 On accept with LoadRes=0: Result and ResValid unchanged except by REQ-021.
REQ-021 ResValid & ResReady without new LoadRes=1 accept clears ResValid; Result holds last value.
REQ-022 Simultaneous drain and LoadRes=1 accept: Result replaced, ResValid stays 1, no beat lost or duplicated.
REQ-023 ResValid=1, ResReady=0: InReady=0; Result, IFlags stable; InValid without accept has no effect.
REQ-024 Cond encoding: 0 BRA(1), 1 BRN(0), 2 HI(!C&!Z), 3 LS(C|Z), 4 CC(!C), 5 CS(C), 6 NE(!Z), 7 EQ(Z), 8 VC(!V), 9 VS(V), 10 PL(!N), 11 MI(N), 12 GE(N==V), 13 LT(N!=V), 14 GT(!Z&(N==V)), 15 LE(Z|(N!=V)).
REQ-025 FlagMask=0 on accept: flags unchanged; result path unaffected.

Reset
REQ-026 Reset=1 at edge: Result=0, ResValid=0, IFlags=0, saved flags=0; InReady=1 the cycle after.
REQ-027 Reset overrides any same-cycle accept, drain, save or restore; in-flight result discarded.

Configuration
REQ-028 Macro ALU_FLAG_SAVE_EN compiles in ports FlagSave(in,1), FlagRestore(in,1), SavedFlags(out,FlagBits) and a shadow flag register.
REQ-029 With macro: FlagSave copies IFlags to shadow; FlagRestore loads IFlags from shadow, overriding same-cycle REQ-018 flag update (result path still proceeds); both asserted swap IFlags and shadow.
REQ-030 Without macro: ports and shadow absent; flags change only via REQ-018 and reset.

Structure
REQ-031 Shared package holds flag bit indices (Zero=0, Carry=1, Neg=2, Over=3) and the 16 Cond code constants, shared with the ALU and sequencer.
REQ-032 Condition evaluation SHALL be sub-module cond_eval (pure combinational, Cond + flags -> CondTrue).

Verification
REQ-033 Reset, then Y=0x80, OFlags=4'b1100, FlagMask=4'b1111, LoadRes=1, accept -> next cycle Result=0x80, ResValid=1, IFlags=4'b1100, Cond=13 (LT) CondTrue=0.
REQ-034 IFlags=4'b0010, OFlags=4'b0001, FlagMask=4'b0001, LoadRes=0 -> IFlags=4'b0011, ResValid unchanged, Cond=3 (LS) CondTrue=1.
REQ-035 ResValid=1, ResReady=0, InValid=1 Y=0x55 for 3 cycles -> InReady=0, Result unchanged; ResReady=1 -> same edge accepts 0x55, ResValid stays 1.
REQ-036 Streams 0x01..0x10 with random ResReady -> downstream sees all 16 in order, none duplicated.
REQ-037 Reset asserted with ResValid=1 and InValid=1 -> next cycle ResValid=0, IFlags=0, Result=0.
REQ-038 ALU_FLAG_SAVE_EN: IFlags=4'b1010, FlagSave; flags-only accept sets 4'b0101; FlagRestore -> IFlags=4'b1010.
